// File: rtl/ysyx_041514_ifu_fetch_resp.sv
// Fetch responder: turns one PC-register fetch request into a single-beat instruction
// memory read and holds the resulting word for the IF stage until it is consumed or flushed.
//
// state | meaning
// IDLE  | no fetch outstanding, waiting for read_req_i
// REQ   | bus request presented, waiting for mem_req_ready_i
// WAIT  | request accepted, waiting for mem_rsp_valid_i
// HOLD  | instruction (or misalign fault) presented to IF until consumed or flushed
// DROP  | fetch killed, swallowing the response still owed by the bus
module ysyx_041514_ifu_fetch_resp #(
  parameter int          ADDR_W   = 32,
  parameter int          XLEN     = 64,
  parameter int          BUS_W    = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_req_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [BUS_W-1:0]  mem_rsp_data_i,
  input  logic              mem_rsp_err_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [XLEN-1:0]   inst_pc_o,
  output logic [1:0]        inst_err_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   kill_q, kill_d;
  logic   sel_q, sel_d;

  logic              mem_req_valid_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              inst_valid_d;
  logic [31:0]       inst_d;
  logic [XLEN-1:0]   inst_pc_d;
  logic [1:0]        inst_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      kill_q          <= 1'b0;
      sel_q           <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_addr_o      <= '0;
      inst_valid_o    <= 1'b0;
      inst_o          <= '0;
      inst_pc_o       <= RESET_PC[XLEN-1:0];
      inst_err_o      <= 2'b00;
      busy_o          <= 1'b0;
    end else begin
      state_q         <= state_d;
      kill_q          <= kill_d;
      sel_q           <= sel_d;
      mem_req_valid_o <= mem_req_valid_d;
      mem_addr_o      <= mem_addr_d;
      inst_valid_o    <= inst_valid_d;
      inst_o          <= inst_d;
      inst_pc_o       <= inst_pc_d;
      inst_err_o      <= inst_err_d;
      busy_o          <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d         = state_q;
    kill_d          = kill_q;
    sel_d           = sel_q;
    mem_req_valid_d = mem_req_valid_o;
    mem_addr_d      = mem_addr_o;
    inst_valid_d    = inst_valid_o;
    inst_d          = inst_o;
    inst_pc_d       = inst_pc_o;
    inst_err_d      = inst_err_o;

    case (state_q)
      IDLE: begin
        if (read_req_i && !flush_i) begin
          sel_d     = pc_i[2];
          kill_d    = 1'b0;
          inst_pc_d = {{(XLEN-ADDR_W){1'b0}}, pc_i};
          if (pc_i[1:0] != 2'b00) begin
            // misaligned fetch is reported directly, the bus is never touched
            state_d      = HOLD;
            inst_valid_d = 1'b1;
            inst_d       = '0;
            inst_err_d   = 2'b10;
          end else begin
            state_d         = REQ;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = {pc_i[ADDR_W-1:3], 3'b000};
          end
        end
      end
      REQ: begin
        // a flush cannot retract the request; remember it and drop the response later
        if (flush_i) kill_d = 1'b1;
        if (mem_req_ready_i) begin
          mem_req_valid_d = 1'b0;
          kill_d          = 1'b0;
          state_d         = (kill_q || flush_i) ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            state_d      = HOLD;
            inst_valid_d = 1'b1;
            inst_d       = sel_q ? mem_rsp_data_i[63:32] : mem_rsp_data_i[31:0];
            inst_err_d   = mem_rsp_err_i ? 2'b01 : 2'b00;
          end
        end else if (flush_i) begin
          state_d = DROP;
        end
      end
      HOLD: begin
        if (flush_i || !stall_i) begin
          state_d      = IDLE;
          inst_valid_d = 1'b0;
        end
      end
      DROP: begin
        if (mem_rsp_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_041514_ifu_fetch_resp.sv
// Self-checking bench for the fetch responder: expected instructions are queued when the
// memory response is driven and popped when inst_valid_o appears.
module tb_ysyx_041514_ifu_fetch_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_req_i;
  logic [31:0] pc_i;
  logic        stall_i;
  logic        flush_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_rsp_valid_i;
  logic [63:0] mem_rsp_data_i;
  logic        mem_rsp_err_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic [1:0]  inst_err_o;
  logic        busy_o;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  ysyx_041514_ifu_fetch_resp dut (
    .clk(clk), .rst(rst), .read_req_i(read_req_i), .pc_i(pc_i), .stall_i(stall_i),
    .flush_i(flush_i), .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .mem_rsp_err_i(mem_rsp_err_i), .inst_valid_o(inst_valid_o), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_err_o(inst_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] pc, input logic [63:0] d);
    return pc[2] ? d[63:32] : d[31:0];
  endfunction

  task automatic wait_inst(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (inst_valid_o) begin
        got = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({mem_req_valid_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_err_o, busy_o} !==
        {1'b0, 32'h0, 1'b0, 32'h0, 64'h8000_0000, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: rv=%b addr=%h iv=%b inst=%h pc=%h err=%b busy=%b, want 0/0/0/0/80000000/0/0",
               mem_req_valid_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_err_o, busy_o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] pc = 32'h8000_0004;
    logic [63:0] d  = 64'hAAAA_BBBB_CCCC_DDDD;
    read_req_i = 1'b1; pc_i = pc; mem_req_ready_i = 1'b1;
    tick();
    read_req_i = 1'b0;
    n_checks++;
    if ({mem_req_valid_o, mem_addr_o, busy_o} !== {1'b1, 32'h8000_0000, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_req: valid=%b addr=%h busy=%b, want 1/80000000/1", mem_req_valid_o, mem_addr_o, busy_o);
    end
    tick();
    n_checks++;
    if ({mem_req_valid_o, inst_valid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_wait: req_valid=%b inst_valid=%b, want 0/0", mem_req_valid_o, inst_valid_o);
    end
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = d; mem_rsp_err_i = 1'b0;
    sb.push_back('{model_word(pc, d), {32'h0, pc}, 2'b00});
    tick();
    mem_rsp_valid_i = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if ({inst_valid_o, inst_o, inst_pc_o, inst_err_o} !== {1'b1, e.inst, e.pc, e.err}) begin
      n_fail++;
      $display("FAIL basic_inst: valid=%b inst=%h pc=%h err=%b, want 1/%h/%h/%b",
               inst_valid_o, inst_o, inst_pc_o, inst_err_o, e.inst, e.pc, e.err);
    end
    tick();
    n_checks++;
    if ({inst_valid_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_done: inst_valid=%b busy=%b, want 0/0", inst_valid_o, busy_o);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pc = 32'h8000_000C;
    logic [63:0] d  = 64'h1111_2222_3333_4444;
    bit got;
    int pulses = 0;
    mem_req_ready_i = 1'b0;
    read_req_i = 1'b1; pc_i = pc;
    tick();
    read_req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_req_ready_i = 1'b1;
      n_checks++;
      if ({mem_req_valid_o, mem_addr_o, busy_o} !== {1'b1, 32'h8000_0008, 1'b1}) begin
        n_fail++;
        $display("FAIL bp_req_stable[%0d]: valid=%b addr=%h busy=%b, want 1/80000008/1",
                 k, mem_req_valid_o, mem_addr_o, busy_o);
      end
      tick();
    end
    mem_req_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({mem_req_valid_o, inst_valid_o, busy_o} !== 3'b001) begin
        n_fail++;
        $display("FAIL bp_wait[%0d]: req_valid=%b inst_valid=%b busy=%b, want 0/0/1",
                 k, mem_req_valid_o, inst_valid_o, busy_o);
      end
      tick();
    end
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = d;
    sb.push_back('{model_word(pc, d), {32'h0, pc}, 2'b00});
    tick();
    mem_rsp_valid_i = 1'b0;
    wait_inst(got);
    e = sb.pop_front();
    n_checks++;
    if (!got || inst_o !== e.inst || inst_pc_o !== e.pc) begin
      n_fail++;
      $display("FAIL bp_inst: got=%b inst=%h pc=%h, want 1/%h/%h", got, inst_o, inst_pc_o, e.inst, e.pc);
    end
    for (int k = 0; k < 4; k++) begin
      if (inst_valid_o) pulses++;
      tick();
    end
    n_checks++;
    if (pulses != 1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_pulse: pulses=%0d busy=%b, want 1/0", pulses, busy_o);
    end
    mem_req_ready_i = 1'b1;
  endtask

  task automatic test_stall();
    logic [31:0] pc = 32'h8000_0020;
    logic [63:0] d  = 64'hDEAD_BEEF_0BAD_F00D;
    stall_i = 1'b1;
    read_req_i = 1'b1; pc_i = pc;
    tick();
    read_req_i = 1'b0;
    tick();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = d;
    sb.push_back('{model_word(pc, d), {32'h0, pc}, 2'b00});
    tick();
    mem_rsp_valid_i = 1'b0; mem_rsp_data_i = 64'h0;
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({inst_valid_o, inst_o, inst_pc_o, busy_o} !== {1'b1, e.inst, e.pc, 1'b1}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b inst=%h pc=%h busy=%b, want 1/%h/%h/1",
                 k, inst_valid_o, inst_o, inst_pc_o, busy_o, e.inst, e.pc);
      end
      tick();
    end
    stall_i = 1'b0;
    n_checks++;
    if ({inst_valid_o, inst_o} !== {1'b1, e.inst}) begin
      n_fail++;
      $display("FAIL stall_release: valid=%b inst=%h, want 1/%h", inst_valid_o, inst_o, e.inst);
    end
    tick();
    n_checks++;
    if ({inst_valid_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_after: valid=%b busy=%b, want 0/0", inst_valid_o, busy_o);
    end
  endtask

  task automatic test_flush();
    logic [31:0] pc = 32'h8000_0010;
    logic [63:0] d  = 64'h5555_6666_7777_8888;
    bit got;
    // flush while waiting, response two cycles later must vanish
    read_req_i = 1'b1; pc_i = 32'h8000_0008;
    tick();
    read_req_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_checks++;
    if ({inst_valid_o, busy_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_drop: valid=%b busy=%b, want 0/1", inst_valid_o, busy_o);
    end
    tick();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    mem_rsp_valid_i = 1'b0;
    n_checks++;
    if ({inst_valid_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_discard: valid=%b busy=%b, want 0/0", inst_valid_o, busy_o);
    end
    read_req_i = 1'b1; pc_i = pc;
    tick();
    read_req_i = 1'b0;
    tick();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = d;
    sb.push_back('{model_word(pc, d), {32'h0, pc}, 2'b00});
    tick();
    mem_rsp_valid_i = 1'b0;
    wait_inst(got);
    e = sb.pop_front();
    n_checks++;
    if (!got || inst_o !== e.inst || inst_pc_o !== e.pc) begin
      n_fail++;
      $display("FAIL flush_next: got=%b inst=%h pc=%h, want 1/%h/%h", got, inst_o, inst_pc_o, e.inst, e.pc);
    end
    tick();
    // flush together with the response
    read_req_i = 1'b1; pc_i = 32'h8000_0018;
    tick();
    read_req_i = 1'b0;
    tick();
    mem_rsp_valid_i = 1'b1; flush_i = 1'b1;
    tick();
    mem_rsp_valid_i = 1'b0; flush_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({inst_valid_o, busy_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL flush_same[%0d]: valid=%b busy=%b, want 0/0", k, inst_valid_o, busy_o);
      end
      tick();
    end
    // flush while the request is still waiting for ready
    mem_req_ready_i = 1'b0;
    read_req_i = 1'b1; pc_i = 32'h8000_0030;
    tick();
    read_req_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; mem_req_ready_i = 1'b1;
    n_checks++;
    if (mem_req_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_req_hold: req_valid=%b, want 1", mem_req_valid_o);
    end
    tick();
    mem_rsp_valid_i = 1'b1;
    tick();
    mem_rsp_valid_i = 1'b0;
    n_checks++;
    if ({inst_valid_o, busy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_req_drop: valid=%b busy=%b, want 0/0", inst_valid_o, busy_o);
    end
  endtask

  task automatic test_error();
    logic [31:0] pc = 32'h8000_0044;
    logic [63:0] d  = 64'hCAFE_0001_CAFE_0002;
    bit got;
    bit saw_req = 1'b0;
    read_req_i = 1'b1; pc_i = pc;
    tick();
    read_req_i = 1'b0;
    tick();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = d; mem_rsp_err_i = 1'b1;
    sb.push_back('{model_word(pc, d), {32'h0, pc}, 2'b01});
    tick();
    mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0;
    wait_inst(got);
    e = sb.pop_front();
    n_checks++;
    if (!got || inst_o !== e.inst || inst_err_o !== e.err) begin
      n_fail++;
      $display("FAIL err_access: got=%b inst=%h err=%b, want 1/%h/%b", got, inst_o, inst_err_o, e.inst, e.err);
    end
    tick();
    pc = 32'h8000_0002;
    read_req_i = 1'b1; pc_i = pc;
    sb.push_back('{32'h0, {32'h0, pc}, 2'b10});
    tick();
    read_req_i = 1'b0;
    saw_req = mem_req_valid_o;
    e = sb.pop_front();
    n_checks++;
    if ({inst_valid_o, inst_o, inst_pc_o, inst_err_o} !== {1'b1, e.inst, e.pc, e.err}) begin
      n_fail++;
      $display("FAIL err_misalign: valid=%b inst=%h pc=%h err=%b, want 1/%h/%h/%b",
               inst_valid_o, inst_o, inst_pc_o, inst_err_o, e.inst, e.pc, e.err);
    end
    tick();
    saw_req = saw_req | mem_req_valid_o;
    n_checks++;
    if (saw_req || inst_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_misalign_nobus: saw_req=%b valid=%b busy=%b, want 0/0/0", saw_req, inst_valid_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    read_req_i = 1'b1; pc_i = 32'h8000_0014;
    tick();
    read_req_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 64'h9999_8888_7777_6666;
    tick();
    mem_rsp_valid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({mem_req_valid_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_err_o, busy_o} !==
          {1'b0, 32'h0, 1'b0, 32'h0, 64'h8000_0000, 2'b00, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: rv=%b addr=%h iv=%b inst=%h pc=%h err=%b busy=%b, want reset values",
                 k, mem_req_valid_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_err_o, busy_o);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; read_req_i = 1'b0; pc_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0; mem_rsp_err_i = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_basic();
    test_backpressure();
    test_stall();
    test_flush();
    test_error();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
